// File: rtl/prior_encoder_iter.sv
// Iterative priority encoder: accepts one vector and emits the index of every set bit,
// one index per handshaked beat, MSB-first or LSB-first as chosen per vector.
module prior_encoder_iter #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   lsb_first,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INDEX_WIDTH-1:0] idx_out,
   output logic                   idx_last,
   output logic                   zero_out
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state, nxt_state;
   logic [DATA_WIDTH-1:0]   pending, nxt_pending;
   logic                    mode, nxt_mode;
   logic                    zero_flag, nxt_zero;
   logic                    accept, beat_done;

   function automatic logic [INDEX_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] v,
                                                     input logic lsb);
      encode = '0;
      // Later hits overwrite earlier ones, so the scan order picks the winner.
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (lsb) begin
            if (v[DATA_WIDTH-1-i]) encode = INDEX_WIDTH'(DATA_WIDTH-1-i);
         end else begin
            if (v[i]) encode = INDEX_WIDTH'(i);
         end
      end
   endfunction

   function automatic logic single_bit(input logic [DATA_WIDTH-1:0] v);
      single_bit = (v != '0) && ((v & (v - ONE)) == '0);
   endfunction

   assign beat_done = out_valid && out_ready;
   assign in_ready  = (state == IDLE) || (beat_done && idx_last);
   assign accept    = in_valid && in_ready;

   always_comb begin
      nxt_state   = state;
      nxt_pending = pending;
      nxt_mode    = mode;
      nxt_zero    = zero_flag;
      if (beat_done) begin
         nxt_pending = pending & ~(ONE << idx_out);
         if (idx_last) nxt_state = IDLE;
      end
      if (accept) begin
         nxt_pending = data_in;
         nxt_mode    = lsb_first;
         nxt_zero    = (data_in == '0);
         nxt_state   = EMIT;
      end
   end

   // Outputs are registered from the next-state view so they change only on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         mode      <= 1'b0;
         zero_flag <= 1'b0;
         out_valid <= 1'b0;
         idx_out   <= '0;
         idx_last  <= 1'b0;
         zero_out  <= 1'b0;
      end else begin
         state     <= nxt_state;
         pending   <= nxt_pending;
         mode      <= nxt_mode;
         zero_flag <= nxt_zero;
         if (nxt_state == EMIT) begin
            out_valid <= 1'b1;
            idx_out   <= encode(nxt_pending, nxt_mode);
            idx_last  <= nxt_zero || single_bit(nxt_pending);
            zero_out  <= nxt_zero;
         end else begin
            out_valid <= 1'b0;
            idx_out   <= '0;
            idx_last  <= 1'b0;
            zero_out  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prior_encoder_iter.sv
// Directed bench for prior_encoder_iter: reset, both orders, zero vector,
// backpressure with back-to-back vectors, and reset mid-vector.
module tb_prior_encoder_iter;

   localparam int DW = 8;
   localparam int IW = $clog2(DW) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] data_in = '0;
   logic          lsb_first = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [IW-1:0] idx_out;
   logic          idx_last;
   logic          zero_out;

   int checks = 0;
   int errors = 0;

   prior_encoder_iter #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .lsb_first(lsb_first),
      .out_valid(out_valid), .out_ready(out_ready),
      .idx_out(idx_out), .idx_last(idx_last), .zero_out(zero_out)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      step();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || idx_out !== '0 || idx_last !== 1'b0 || zero_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b idx=%0d last=%b zero=%b, required 0 0 0 0",
                  out_valid, idx_out, idx_last, zero_out);
      end
      step();
      step();
      #1 rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_msb_first();
      int exp_idx[3] = '{7, 5, 2};
      data_in = 8'b1010_0100; lsb_first = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL msb_pre_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || idx_out !== IW'(exp_idx[k]) || idx_last !== (k == 2) || zero_out !== 1'b0) begin
            errors++;
            $display("FAIL msb_beat%0d: valid=%b idx=%0d last=%b zero=%b, required 1 %0d %b 0",
                     k, out_valid, idx_out, idx_last, zero_out, exp_idx[k], (k == 2));
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL msb_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_lsb_first();
      int exp_idx[3] = '{2, 5, 7};
      data_in = 8'b1010_0100; lsb_first = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; lsb_first = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || idx_out !== IW'(exp_idx[k]) || idx_last !== (k == 2) || zero_out !== 1'b0) begin
            errors++;
            $display("FAIL lsb_beat%0d: valid=%b idx=%0d last=%b zero=%b, required 1 %0d %b 0",
                     k, out_valid, idx_out, idx_last, zero_out, exp_idx[k], (k == 2));
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lsb_idle: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_zero_vector();
      data_in = 8'h00; lsb_first = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || idx_out !== '0 || zero_out !== 1'b1 || idx_last !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_beat: valid=%b idx=%0d zero=%b last=%b in_ready=%b, required 1 0 1 1 1",
                  out_valid, idx_out, zero_out, idx_last, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || zero_out !== 1'b0) begin
         errors++;
         $display("FAIL zero_single: out_valid=%b zero_out=%b, required 0 0", out_valid, zero_out);
      end
   endtask

   task automatic test_back_to_back();
      data_in = 8'h81; lsb_first = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      step();
      data_in = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || idx_out !== IW'(7) || idx_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d: valid=%b idx=%0d last=%b in_ready=%b, required 1 7 0 0",
                     k, out_valid, idx_out, idx_last, in_ready);
         end
         if (k < 2) step();
      end
      out_ready = 1'b1;
      step();
      #1;
      checks++;
      if (out_valid !== 1'b1 || idx_out !== '0 || idx_last !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: valid=%b idx=%0d last=%b in_ready=%b, required 1 0 1 1",
                  out_valid, idx_out, idx_last, in_ready);
      end
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (out_valid !== 1'b1 || idx_out !== IW'(7 - k) || idx_last !== (k == 7) || zero_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ff%0d: valid=%b idx=%0d last=%b zero=%b, required 1 %0d %b 0",
                     k, out_valid, idx_out, idx_last, zero_out, 7 - k, (k == 7));
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_vector();
      data_in = 8'hF0; lsb_first = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || idx_out !== IW'(6)) begin
         errors++;
         $display("FAIL mid_second_beat: valid=%b idx=%0d, required 1 6", out_valid, idx_out);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || idx_out !== '0 || idx_last !== 1'b0 || zero_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b idx=%0d last=%b zero=%b, required 0 0 0 0",
                  out_valid, idx_out, idx_last, zero_out);
      end
      step();
      #1 rst_n = 1'b1;
      step();
      data_in = 8'h02; lsb_first = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || idx_out !== IW'(1) || idx_last !== 1'b1 || zero_out !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_beat: valid=%b idx=%0d last=%b zero=%b, required 1 1 1 0",
                  out_valid, idx_out, idx_last, zero_out);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_stale: out_valid=%b idx=%0d, required 0", out_valid, idx_out);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_zero_vector();
      test_back_to_back();
      test_reset_mid_vector();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
